// File: rtl/memory_access.sv
// RV32i memory-stage load/store unit: request/ack data-memory port, byte lanes, load extension.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Mem_Read_M,
  input  logic        Mem_Write_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] ALU_Out_M,
  input  logic [31:0] REG_R_Data2_M,
  output logic        DMEM_Req,
  output logic        DMEM_We,
  output logic [31:0] DMEM_Addr,
  output logic [31:0] DMEM_WData,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_Ack,
  input  logic [31:0] DMEM_RData,
  output logic [31:0] Load_Data_M,
  output logic        Stall_M,
  output logic        Bus_Err_M,
  output logic        Misaligned_M
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          legal;
  logic          misalign;
  logic          ok;
  logic          is_load;
  logic [1:0]    addr_lo;
  logic [31:0]   lane;
  logic [31:0]   load_ext;
  logic          timeout_hit;

  assign is_load = Mem_Read_M & ~Mem_Write_M;

  always_comb begin
    legal = 1'b0;
    if (Mem_Write_M)
      legal = (Funct3_M == 3'b000) || (Funct3_M == 3'b001) || (Funct3_M == 3'b010);
    else if (Mem_Read_M)
      legal = (Funct3_M == 3'b000) || (Funct3_M == 3'b001) || (Funct3_M == 3'b010) ||
              (Funct3_M == 3'b100) || (Funct3_M == 3'b101);
  end

  assign misalign = ((Funct3_M[1:0] == 2'b01) && ALU_Out_M[0]) ||
                    ((Funct3_M[1:0] == 2'b10) && (ALU_Out_M[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign ok           = legal & ~misalign;
  assign Misaligned_M = legal & misalign;
  assign addr_lo      = ALU_Out_M[1:0];
`else
  // Without the trap, misaligned accesses silently snap to natural alignment.
  assign ok           = legal;
  assign Misaligned_M = 1'b0;
  always_comb begin
    addr_lo = ALU_Out_M[1:0];
    if (Funct3_M[1:0] == 2'b01)      addr_lo = {ALU_Out_M[1], 1'b0};
    else if (Funct3_M[1:0] == 2'b10) addr_lo = 2'b00;
  end
`endif

  assign DMEM_Req   = ((state == IDLE) && ok) || (state == WAIT);
  assign Stall_M    = DMEM_Req;
  assign DMEM_We    = Mem_Write_M;
  assign DMEM_Addr  = {ALU_Out_M[31:2], 2'b00};

  always_comb begin
    DMEM_BE    = 4'b1111;
    DMEM_WData = REG_R_Data2_M;
    if (Mem_Write_M) begin
      case (Funct3_M[1:0])
        2'b00: begin
          DMEM_BE    = 4'b0001 << addr_lo;
          DMEM_WData = {4{REG_R_Data2_M[7:0]}};
        end
        2'b01: begin
          DMEM_BE    = addr_lo[1] ? 4'b1100 : 4'b0011;
          DMEM_WData = {2{REG_R_Data2_M[15:0]}};
        end
        default: DMEM_BE = 4'b1111;
      endcase
    end
  end

  assign lane = DMEM_RData >> {addr_lo, 3'b000};

  always_comb begin
    case (Funct3_M)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = DMEM_RData;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // DMEM_Req is low in IDLE-without-access and in DONE, so both fall back to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      Load_Data_M <= 32'h0;
      Bus_Err_M   <= 1'b0;
    end else begin
      Bus_Err_M <= 1'b0;
      if (DMEM_Req) begin
        if (DMEM_Ack) begin
          state <= DONE;
          cnt   <= '0;
          if (is_load) Load_Data_M <= load_ext;
        end else if (timeout_hit) begin
          state       <= DONE;
          cnt         <= '0;
          Bus_Err_M   <= 1'b1;
          Load_Data_M <= 32'h0;
        end else begin
          state <= WAIT;
          cnt   <= cnt + 1'b1;
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access (TIMEOUT_CYCLES=4).
module tb_memory_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Mem_Read_M, Mem_Write_M;
  logic [2:0]  Funct3_M;
  logic [31:0] ALU_Out_M, REG_R_Data2_M;
  logic        DMEM_Req, DMEM_We;
  logic [31:0] DMEM_Addr, DMEM_WData;
  logic [3:0]  DMEM_BE;
  logic        DMEM_Ack;
  logic [31:0] DMEM_RData;
  logic [31:0] Load_Data_M;
  logic        Stall_M, Bus_Err_M, Misaligned_M;

  int n_asrt = 0;
  int n_fail = 0;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M), .Funct3_M(Funct3_M),
    .ALU_Out_M(ALU_Out_M), .REG_R_Data2_M(REG_R_Data2_M),
    .DMEM_Req(DMEM_Req), .DMEM_We(DMEM_We), .DMEM_Addr(DMEM_Addr),
    .DMEM_WData(DMEM_WData), .DMEM_BE(DMEM_BE), .DMEM_Ack(DMEM_Ack),
    .DMEM_RData(DMEM_RData), .Load_Data_M(Load_Data_M), .Stall_M(Stall_M),
    .Bus_Err_M(Bus_Err_M), .Misaligned_M(Misaligned_M)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rdat);
    Mem_Read_M    = rd;
    Mem_Write_M   = wr;
    Funct3_M      = f3;
    ALU_Out_M     = addr;
    REG_R_Data2_M = wd;
    DMEM_Ack      = ack;
    DMEM_RData    = rdat;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    nop();
    tick();
    tick();
    check("rst_req", DMEM_Req, 1'b0);
    check("rst_stall", Stall_M, 1'b0);
    check("rst_load", Load_Data_M, 32'h0);
    check("rst_buserr", Bus_Err_M, 1'b0);
    RST = 1'b0;
    tick();

    // SW 0x100, ack in request cycle
    drive(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
    check("sw_req", DMEM_Req, 1'b1);
    check("sw_stall", Stall_M, 1'b1);
    check("sw_we", DMEM_We, 1'b1);
    check("sw_addr", DMEM_Addr, 32'h100);
    check("sw_be", DMEM_BE, 4'b1111);
    check("sw_wdata", DMEM_WData, 32'hDEADBEEF);
    tick();
    DMEM_Ack = 1'b0;
    #1;
    check("sw_done_req", DMEM_Req, 1'b0);
    check("sw_done_stall", Stall_M, 1'b0);
    tick();

    // SB 0x103
    drive(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b1, 32'h0);
    check("sb_req", DMEM_Req, 1'b1);
    check("sb_be", DMEM_BE, 4'b1000);
    check("sb_wdata", DMEM_WData, 32'hA5A5A5A5);
    check("sb_addr", DMEM_Addr, 32'h100);
    tick();
    DMEM_Ack = 1'b0;
    #1;
    check("sb_done_req", DMEM_Req, 1'b0);
    tick();

    // SH 0x102: upper half lanes
    drive(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 1'b1, 32'h0);
    check("sh_be", DMEM_BE, 4'b1100);
    check("sh_wdata", DMEM_WData, 32'h12341234);
    tick();
    DMEM_Ack = 1'b0;
    tick();

    // LW with no ack: times out after 4 request cycles
    drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h55555555);
    check("to_req1", DMEM_Req, 1'b1);
    check("to_be", DMEM_BE, 4'b1111);
    check("to_we", DMEM_We, 1'b0);
    tick();
    check("to_req2", DMEM_Req, 1'b1);
    tick();
    check("to_req3", DMEM_Req, 1'b1);
    tick();
    check("to_req4", DMEM_Req, 1'b1);
    tick();
    check("to_done_req", DMEM_Req, 1'b0);
    check("to_done_buserr", Bus_Err_M, 1'b1);
    check("to_done_load", Load_Data_M, 32'h0);
    tick();
    nop();
    check("to_after_buserr", Bus_Err_M, 1'b0);
    check("to_after_req", DMEM_Req, 1'b0);

    // LB 0x102, ack in the third wait cycle
    drive(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 1'b0, 32'h0080FF00);
    check("lb_stall1", Stall_M, 1'b1);
    tick();
    check("lb_stall2", Stall_M, 1'b1);
    check("lb_load_hold", Load_Data_M, 32'h0);
    tick();
    check("lb_stall3", Stall_M, 1'b1);
    tick();
    DMEM_Ack = 1'b1;
    #1;
    check("lb_stall4", Stall_M, 1'b1);
    tick();
    DMEM_Ack = 1'b0;
    #1;
    check("lb_done_stall", Stall_M, 1'b0);
    check("lb_done_load", Load_Data_M, 32'hFFFFFF80);
    check("lb_done_buserr", Bus_Err_M, 1'b0);
    tick();

    // LHU 0x102, immediate ack
    drive(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 32'h0080FF00);
    check("lhu_req", DMEM_Req, 1'b1);
    tick();
    DMEM_Ack = 1'b0;
    #1;
    check("lhu_done_load", Load_Data_M, 32'h00000080);
    tick();

    // Illegal funct3 load and store, then a stray ack
    drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'hFFFFFFFF);
    check("ill_ld_req", DMEM_Req, 1'b0);
    check("ill_ld_stall", Stall_M, 1'b0);
    check("ill_ld_mis", Misaligned_M, 1'b0);
    tick();
    check("ill_ld_load", Load_Data_M, 32'h00000080);
    drive(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1'b1, 32'hFFFFFFFF);
    check("ill_st_req", DMEM_Req, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h12345678);
    tick();
    check("stray_ack_load", Load_Data_M, 32'h00000080);
    check("stray_ack_req", DMEM_Req, 1'b0);
    nop();

    // LH 0x101 misaligned
    drive(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 32'hABCD8765);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_mis_flag", Misaligned_M, 1'b1);
    check("lh_mis_req", DMEM_Req, 1'b0);
    check("lh_mis_stall", Stall_M, 1'b0);
    tick();
    check("lh_mis_load", Load_Data_M, 32'h00000080);
`else
    check("lh_mis_flag", Misaligned_M, 1'b0);
    check("lh_mis_req", DMEM_Req, 1'b1);
    check("lh_mis_addr", DMEM_Addr, 32'h100);
    tick();
    DMEM_Ack = 1'b0;
    #1;
    check("lh_mis_load", Load_Data_M, 32'hFFFF8765);
`endif
    tick();
    nop();

    // Reset while in WAIT, then a late ack
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 32'hCAFEF00D);
    tick();
    check("rw_wait_req", DMEM_Req, 1'b1);
    RST = 1'b1;
    nop();
    tick();
    RST = 1'b0;
    #1;
    check("rw_req", DMEM_Req, 1'b0);
    check("rw_stall", Stall_M, 1'b0);
    check("rw_load", Load_Data_M, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);
    tick();
    check("rw_late_ack_load", Load_Data_M, 32'h0);
    check("rw_late_ack_req", DMEM_Req, 1'b0);
    nop();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
